crc32_req_arbiter: RTL and testbench

- Shares one byte-serial CRC-32 engine among NUM_REQ byte-stream requesters. The engine uses the reflected polynomial 0xEDB88320, init 0xFFFFFFFF and a final inversion.
- Arbitration is per frame and round-robin. Once a requester is granted, it holds the engine until its last byte has been accepted.
- The block returns the finished CRC, the requester id and the byte count on a valid/ready result port.
- It sits between packet sources and the checksum consumer, replacing one CRC pipeline per source.

---
 rtl/crc32_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_crc32_req_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_req_arbiter.sv
// Shares one byte-serial CRC-32 engine (reflected 0xEDB88320, init/xorout 0xFFFFFFFF) among
// NUM_REQ byte-stream requesters with per-frame round-robin arbitration and a valid/ready result port.
module crc32_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 crc_valid,
    input  logic                 crc_ready,
    output logic [31:0]          crc_out,
    output logic [IDW-1:0]       crc_id,
    output logic [15:0]          crc_len
);
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;

    state_t               state, state_nx;
    logic [IDW-1:0]       rr_ptr, grant, arb_sel, grant_inc;
    logic [31:0]          crc_state, crc_next;
    logic [15:0]          byte_cnt, cnt_next;
    logic [7:0]           g_data;
    logic                 g_valid, g_last, accept;
    logic [NUM_REQ-1:0]   grant_oh;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d_in);
        logic [31:0] c;
        logic [7:0]  d;
        c = c_in;
        d = d_in;
        for (int unsigned k = 0; k < 8; k++) begin
            c = (c >> 1) ^ (32'hEDB88320 & {32{c[0] ^ d[0]}});
            d = d >> 1;
        end
        return c;
    endfunction

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IDW-1:0] ptr);
        logic [IDW-1:0] pick;
        logic [IDW:0]   s;
        logic           found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NR; i++) begin
            s = {1'b0, ptr} + (IDW+1)'(i);
            if (s >= (IDW+1)'(NR))
                s = s - (IDW+1)'(NR);
            if (!found && v[s[IDW-1:0]]) begin
                pick  = s[IDW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        arb_sel   = rr_pick(req_valid, rr_ptr);
        grant_inc = (grant == IDW'(NR - 1)) ? '0 : grant + IDW'(1);
        g_valid   = req_valid[grant];
        g_last    = req_last[grant];
        g_data    = req_data[{grant, 3'b000} +: 8];
        grant_oh  = '0;
        grant_oh[grant] = 1'b1;
        crc_next  = crc_byte(crc_state, g_data);
        cnt_next  = (&byte_cnt) ? byte_cnt : byte_cnt + 16'd1;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid)
                    state_nx = BUSY;
            end
            BUSY: begin
                req_ready = grant_oh;
                accept    = g_valid;
                if (g_valid && g_last)
                    state_nx = RESULT;
            end
            RESULT: begin
                if (crc_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant     <= '0;
            crc_state <= '1;
            byte_cnt  <= '0;
            crc_valid <= 1'b0;
            crc_out   <= '0;
            crc_id    <= '0;
            crc_len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid)
                        grant <= arb_sel;
                end
                BUSY: begin
                    if (accept) begin
                        crc_state <= crc_next;
                        byte_cnt  <= cnt_next;
                        if (g_last) begin
                            crc_out   <= ~crc_next;
                            crc_len   <= cnt_next;
                            crc_id    <= grant;
                            crc_valid <= 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (crc_ready) begin
                        crc_valid <= 1'b0;
                        crc_state <= '1;
                        byte_cnt  <= '0;
                        rr_ptr    <= grant_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_req_arbiter.sv
// Bench for crc32_req_arbiter: per-requester byte queues drive the DUT, and a frame-level model
// (table-driven CRC, modular round-robin search) predicts every cycle's outputs.
module tb_crc32_req_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           crc_valid, crc_ready;
    logic [31:0]    crc_out;
    logic [1:0]     crc_id;
    logic [15:0]    crc_len;

    crc32_req_arbiter #(.NUM_REQ(N), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .crc_valid(crc_valid), .crc_ready(crc_ready),
        .crc_out(crc_out), .crc_id(crc_id), .crc_len(crc_len)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Pending stimulus per requester, each entry {last, data}.
    logic [8:0] pend [N][256];
    int         head [N];
    int         tail [N];
    logic [N-1:0] hold;
    int         gap_pct;
    bit         rand_ready;

    logic [31:0] crc_tab [256];

    // Frame-level reference model.
    int          m_phase;   // 0 waiting for a grant, 1 frame in progress, 2 result pending
    int          m_grant, m_rr, m_len, results;
    logic [7:0]  m_frame [$];
    logic [N-1:0] exp_ready;
    logic        exp_valid;
    logic [31:0] exp_out;
    logic [1:0]  exp_id;
    logic [15:0] exp_len;

    function automatic logic [31:0] crc_ref();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (m_frame[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ m_frame[i]];
        return ~c;
    endfunction

    function automatic logic [54:0] got_vec();
        return {req_ready, crc_valid, crc_out, crc_id, crc_len};
    endfunction

    function automatic logic [54:0] exp_vec();
        return {exp_ready, exp_valid, exp_out, exp_id, exp_len};
    endfunction

    function automatic bit pending();
        bit p;
        p = (m_phase != 0);
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic push_byte(input int r, input logic [7:0] d, input logic last);
        pend[r][tail[r] % 256] = {last, d};
        tail[r]++;
    endtask

    task automatic push_str(input int r, input string s);
        for (int i = 0; i < s.len(); i++) push_byte(r, s[i], i == s.len() - 1);
    endtask

    task automatic push_rand_frame(input int r, input int len);
        for (int i = 0; i < len; i++) push_byte(r, 8'($urandom), i == len - 1);
    endtask

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            e = pend[i][head[i] % 256];
            req_valid[i] = (head[i] != tail[i]) && !hold[i] && ($urandom_range(99) >= gap_pct);
            req_data[8*i +: 8] = req_valid[i] ? e[7:0] : 8'($urandom);
            req_last[i] = req_valid[i] ? e[8] : 1'($urandom);
        end
        if (rand_ready) crc_ready = 1'($urandom);
    endtask

    // Advance the model on the current inputs, clock once, then present the next inputs.
    task automatic step();
        logic [N-1:0] v;
        logic [8:0]   e;
        v = req_valid;
        if (rst) begin
            m_phase = 0; m_rr = 0; m_grant = 0; m_len = 0;
            m_frame.delete();
            exp_valid = 1'b0; exp_out = '0; exp_id = '0; exp_len = '0;
        end else begin
            case (m_phase)
                0: if (v != '0) begin
                    for (int j = N - 1; j >= 0; j--)
                        if (v[(m_rr + j) % N]) m_grant = (m_rr + j) % N;
                    m_phase = 1;
                end
                1: if (v[m_grant]) begin
                    e = pend[m_grant][head[m_grant] % 256];
                    head[m_grant]++;
                    m_frame.push_back(e[7:0]);
                    m_len = (m_len < 65535) ? m_len + 1 : 65535;
                    if (e[8]) begin
                        exp_out = crc_ref(); exp_id = 2'(m_grant); exp_len = 16'(m_len);
                        exp_valid = 1'b1; m_phase = 2; m_len = 0;
                        m_frame.delete();
                        results++;
                    end
                end
                default: if (crc_ready) begin
                    exp_valid = 1'b0; m_rr = (m_grant + 1) % N; m_phase = 0;
                end
            endcase
        end
        exp_ready = (m_phase == 1) ? (4'b0001 << m_grant) : 4'b0000;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++;
        if (crc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", crc_valid); end
        checks++;
        if (crc_out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 00000000", crc_out); end
        checks++;
        if (crc_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", crc_id); end
        checks++;
        if (crc_len !== 16'd0) begin errors++; $display("FAIL reset_len got %0d want 0", crc_len); end
        checks++;
        rst = 1'b0;
    endtask

    task automatic test_check_value();
        int   target;
        logic hs_last;
        crc_ready = 1'b1;
        push_str(0, "123456789");
        drive();
        target = results + 1;
        for (int c = 0; c < 60 && results < target; c++) begin
            hs_last = req_valid[0] & req_ready[0] & req_last[0];
            step();
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL check_value_cycle got %h want %h", got_vec(), exp_vec()); end
            checks++;
            if (hs_last) begin
                checks++;
                if (crc_valid !== 1'b1) begin errors++; $display("FAIL check_value_latency crc_valid=%b want 1", crc_valid); end
            end
        end
        if (results < target) begin errors++; $display("FAIL check_value_timeout results=%0d want %0d", results, target); end
        checks++;
        if (crc_out !== 32'hCBF43926) begin errors++; $display("FAIL check_value_out got %h want cbf43926", crc_out); end
        checks++;
        if (crc_id !== 2'd0 || crc_len !== 16'd9) begin errors++; $display("FAIL check_value_idlen got id=%0d len=%0d want id=0 len=9", crc_id, crc_len); end
        checks++;
        step();
        if (crc_valid !== 1'b0) begin errors++; $display("FAIL check_value_consume crc_valid=%b want 0", crc_valid); end
        checks++;
    endtask

    task automatic test_single_byte();
        int          target;
        logic [7:0]  bytes [2];
        logic [31:0] want_crc [2];
        int          who [2];
        bytes = '{8'h00, 8'h61};
        want_crc = '{32'hD202EF8D, 32'hE8B7BE43};
        who = '{2, 1};
        crc_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            push_byte(who[f], bytes[f], 1'b1);
            drive();
            target = results + 1;
            for (int c = 0; c < 20 && results < target; c++) begin
                step();
                if (got_vec() !== exp_vec()) begin errors++; $display("FAIL single_byte_cycle got %h want %h", got_vec(), exp_vec()); end
                checks++;
            end
            if (results < target) begin errors++; $display("FAIL single_byte_timeout frame %0d", f); end
            checks++;
            if ({crc_out, crc_id, crc_len} !== {want_crc[f], 2'(who[f]), 16'd1}) begin
                errors++;
                $display("FAIL single_byte_result got out=%h id=%0d len=%0d want out=%h id=%0d len=1", crc_out, crc_id, crc_len, want_crc[f], who[f]);
            end
            checks++;
            step();
        end
    endtask

    task automatic test_round_robin();
        int target, k;
        rst = 1'b1;
        step();
        rst = 1'b0;
        crc_ready = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < N; r++) push_rand_frame(r, 2);
        drive();
        target = results + 8;
        k = 0;
        for (int c = 0; c < 200 && results < target; c++) begin
            step();
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL round_robin_cycle got %h want %h", got_vec(), exp_vec()); end
            checks++;
            if (!$onehot0(req_ready)) begin errors++; $display("FAIL round_robin_onehot ready=%b", req_ready); end
            checks++;
            if (crc_valid === 1'b1) begin
                if (crc_id !== 2'(k % N)) begin errors++; $display("FAIL round_robin_order result %0d got id %0d want %0d", k, crc_id, k % N); end
                checks++;
                k++;
            end
        end
        if (k != 8) begin errors++; $display("FAIL round_robin_count got %0d results want 8", k); end
        checks++;
        step();
    endtask

    task automatic test_result_hold();
        int          target;
        logic [31:0] c_out;
        logic [1:0]  c_id;
        logic [15:0] c_len;
        for (int r = 0; r < N; r++) push_rand_frame(r, 3);
        crc_ready = 1'b0;
        drive();
        target = results + 1;
        for (int c = 0; c < 30 && results < target; c++) begin
            step();
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL result_hold_cycle got %h want %h", got_vec(), exp_vec()); end
            checks++;
        end
        if (results < target) begin errors++; $display("FAIL result_hold_timeout"); end
        checks++;
        c_out = crc_out; c_id = crc_id; c_len = crc_len;
        for (int c = 0; c < 5; c++) begin
            step();
            if ({crc_valid, crc_out, crc_id, crc_len, req_ready} !== {1'b1, c_out, c_id, c_len, 4'b0}) begin
                errors++;
                $display("FAIL result_hold_stable got v=%b out=%h id=%0d len=%0d ready=%b want v=1 out=%h id=%0d len=%0d ready=0000",
                         crc_valid, crc_out, crc_id, crc_len, req_ready, c_out, c_id, c_len);
            end
            checks++;
        end
        crc_ready = 1'b1;
        step();
        step();
        if (req_ready !== (4'b0001 << ((c_id + 1) % N))) begin
            errors++; $display("FAIL result_hold_next_grant got %b want id %0d", req_ready, (c_id + 1) % N);
        end
        checks++;
        target = results + 3;
        for (int c = 0; c < 60 && results < target; c++) begin
            step();
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL result_hold_drain got %h want %h", got_vec(), exp_vec()); end
            checks++;
        end
        if (results < target) begin errors++; $display("FAIL result_hold_drain_timeout"); end
        checks++;
        step();
    endtask

    task automatic test_idle_hold();
        int target;
        crc_ready = 1'b1;
        push_rand_frame(0, 1);
        drive();
        target = results + 1;
        for (int c = 0; c < 20 && results < target; c++) step();
        if (results < target) begin errors++; $display("FAIL idle_hold_setup_timeout"); end
        checks++;
        step();
        push_rand_frame(0, 2);
        push_rand_frame(1, 4);
        drive();
        step();
        step();
        hold[1] = 1'b1;
        drive();
        for (int c = 0; c < 3; c++) begin
            step();
            if (req_ready !== 4'b0010) begin errors++; $display("FAIL idle_hold_grant got %b want 0010", req_ready); end
            checks++;
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL idle_hold_cycle got %h want %h", got_vec(), exp_vec()); end
            checks++;
        end
        hold[1] = 1'b0;
        drive();
        target = results + 1;
        for (int c = 0; c < 30 && results < target; c++) begin
            step();
            if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL idle_hold_starve ready=%b", req_ready); end
            checks++;
        end
        if (crc_valid !== 1'b1 || crc_id !== 2'd1 || crc_len !== 16'd4) begin
            errors++; $display("FAIL idle_hold_result got v=%b id=%0d len=%0d want v=1 id=1 len=4", crc_valid, crc_id, crc_len);
        end
        checks++;
        target = results + 1;
        for (int c = 0; c < 30 && results < target; c++) begin
            step();
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL idle_hold_next got %h want %h", got_vec(), exp_vec()); end
            checks++;
        end
        if (crc_id !== 2'd0) begin errors++; $display("FAIL idle_hold_second_id got %0d want 0", crc_id); end
        checks++;
        step();
    endtask

    task automatic test_reset_midframe();
        int h0, target;
        crc_ready = 1'b1;
        h0 = head[0];
        push_str(0, "123456789");
        drive();
        for (int c = 0; c < 40 && head[0] - h0 < 4; c++) step();
        if (head[0] - h0 != 4) begin errors++; $display("FAIL reset_mid_setup accepted %0d want 4", head[0] - h0); end
        checks++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        head[0] = tail[0];
        drive();
        if (got_vec() !== 55'h0) begin errors++; $display("FAIL reset_mid_outputs got %h want 0", got_vec()); end
        checks++;
        for (int c = 0; c < 3; c++) begin
            step();
            if (crc_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_no_result crc_valid=%b want 0", crc_valid); end
            checks++;
        end
        push_str(0, "123456789");
        push_byte(3, 8'h5A, 1'b1);
        drive();
        target = results + 1;
        for (int c = 0; c < 40 && results < target; c++) begin
            step();
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL reset_mid_cycle got %h want %h", got_vec(), exp_vec()); end
            checks++;
        end
        if ({crc_valid, crc_out, crc_id, crc_len} !== {1'b1, 32'hCBF43926, 2'd0, 16'd9}) begin
            errors++; $display("FAIL reset_mid_fresh got v=%b out=%h id=%0d len=%0d want v=1 out=cbf43926 id=0 len=9", crc_valid, crc_out, crc_id, crc_len);
        end
        checks++;
        for (int c = 0; c < 20 && pending(); c++) step();
        if (pending()) begin errors++; $display("FAIL reset_mid_drain_timeout"); end
        checks++;
    endtask

    task automatic test_random();
        int r;
        rand_ready = 1'b1;
        gap_pct = 25;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(9) == 0) begin
                r = $urandom_range(N - 1);
                if (tail[r] - head[r] < 200) push_rand_frame(r, $urandom_range(6, 1));
            end
            step();
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL random_cycle %0d got %h want %h", c, got_vec(), exp_vec()); end
            checks++;
        end
        rand_ready = 1'b0;
        gap_pct = 0;
        crc_ready = 1'b1;
        drive();
        for (int c = 0; c < 3000 && pending(); c++) begin
            step();
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL random_drain got %h want %h", got_vec(), exp_vec()); end
            checks++;
        end
        if (pending()) begin errors++; $display("FAIL random_drain_timeout"); end
        checks++;
    endtask

    initial begin
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        hold = '0; gap_pct = 0; rand_ready = 1'b0; results = 0;
        m_phase = 0; m_rr = 0; m_grant = 0; m_len = 0;
        rst = 1'b1; crc_ready = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        #1;
        drive();
        test_reset();
        test_check_value();
        test_single_byte();
        test_round_robin();
        test_result_hold();
        test_idle_hold();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
